// File: rtl/riscv_multicycle_control_if.sv
// Control bundle between the multicycle RISC-V controller and its datapath:
// instruction fields and status flags in, enables, mux selects and status out.
interface riscv_multicycle_control_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        mem_ready;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        PCSource;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUCtl;
    logic        illegal_instr;
    logic [3:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUCtl, illegal_instr, state, instret
    );

    modport slave (
        output opcode, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUCtl, illegal_instr, state, instret
    );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Moore-style multicycle control FSM for a RISC-V subset (lw, sw, R/I ALU ops, beq)
// with an illegal-instruction pulse and a retired-instruction counter.
module riscv_multicycle_control (
    input logic                          clock,
    input logic                          reset,
    riscv_multicycle_control_if.master   ctl
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [3:0] AluAnd = 4'd0;
    localparam logic [3:0] AluOr  = 4'd1;
    localparam logic [3:0] AluAdd = 4'd2;
    localparam logic [3:0] AluSub = 4'd6;
    localparam logic [3:0] AluSlt = 4'd7;
    localparam logic [3:0] AluXor = 4'd12;

    state_e      state_q, state_d;
    logic [31:0] instret_q;
    logic        retire;
    logic        funct_legal;
    logic [3:0]  alu_op;

    // funct7b5 only selects SUB for R-type funct3=000; I-type 000 is always ADD.
    always_comb begin
        funct_legal = 1'b1;
        alu_op      = AluAdd;
        case (ctl.funct3)
            3'b000:  alu_op = (ctl.opcode == OpRtype && ctl.funct7b5) ? AluSub : AluAdd;
            3'b111:  alu_op = AluAnd;
            3'b110:  alu_op = AluOr;
            3'b100:  alu_op = AluXor;
            3'b010:  alu_op = AluSlt;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d           = StFetch;
        retire            = 1'b0;
        ctl.PCWrite       = 1'b0;
        ctl.PCWriteCond   = 1'b0;
        ctl.PCSource      = 1'b0;
        ctl.IorD          = 1'b0;
        ctl.MemRead       = 1'b0;
        ctl.MemWrite      = 1'b0;
        ctl.IRWrite       = 1'b0;
        ctl.MemtoReg      = 1'b0;
        ctl.RegWrite      = 1'b0;
        ctl.ALUSrcA       = 1'b0;
        ctl.ALUSrcB       = 2'b00;
        ctl.ALUCtl        = 4'd0;
        ctl.illegal_instr = 1'b0;

        case (state_q)
            StFetch: begin
                ctl.MemRead = 1'b1;
                ctl.ALUSrcB = 2'b01;
                ctl.ALUCtl  = AluAdd;
                ctl.IRWrite = ctl.mem_ready;
                ctl.PCWrite = ctl.mem_ready;
                state_d     = ctl.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                ctl.ALUSrcB = 2'b11;
                ctl.ALUCtl  = AluAdd;
                if (ctl.opcode == OpLoad || ctl.opcode == OpStore) begin
                    state_d = StMemAdr;
                end else if ((ctl.opcode == OpRtype || ctl.opcode == OpItype) && funct_legal) begin
                    state_d = StExec;
                end else if (ctl.opcode == OpBranch && ctl.funct3 == 3'b000) begin
                    state_d = StBranch;
                end else begin
                    ctl.illegal_instr = 1'b1;
                end
            end
            StMemAdr: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = 2'b10;
                ctl.ALUCtl  = AluAdd;
                state_d     = (ctl.opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                ctl.MemRead = 1'b1;
                ctl.IorD    = 1'b1;
                state_d     = ctl.mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                ctl.RegWrite = 1'b1;
                ctl.MemtoReg = 1'b1;
                retire       = 1'b1;
            end
            StMemWr: begin
                ctl.MemWrite = 1'b1;
                ctl.IorD     = 1'b1;
                state_d      = ctl.mem_ready ? StFetch : StMemWr;
                retire       = ctl.mem_ready;
            end
            StExec: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = (ctl.opcode == OpItype) ? 2'b10 : 2'b00;
                ctl.ALUCtl  = alu_op;
                state_d     = StAluWb;
            end
            StAluWb: begin
                ctl.RegWrite = 1'b1;
                retire       = 1'b1;
            end
            StBranch: begin
                ctl.ALUSrcA     = 1'b1;
                ctl.ALUCtl      = AluSub;
                ctl.PCWriteCond = 1'b1;
                ctl.PCSource    = 1'b1;
                retire          = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Architectural side effects are suppressed while reset is held.
        if (reset) begin
            ctl.PCWrite       = 1'b0;
            ctl.PCWriteCond   = 1'b0;
            ctl.IRWrite       = 1'b0;
            ctl.MemRead       = 1'b0;
            ctl.MemWrite      = 1'b0;
            ctl.RegWrite      = 1'b0;
            ctl.illegal_instr = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign ctl.state   = state_q;
    assign ctl.instret = instret_q;
endmodule

// File: doc/riscv_multicycle_control.md
RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 SHALL have inputs: opcode  input  7  IR[6:0]; funct3  input  3  IR[14:12]; funct7b5  input  1  IR[30]; Zero  input  1  ALU zero flag; mem_ready  input  1  memory access completes this cycle.
REQ-003 SHALL have 1-bit outputs PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite and ALUSrcA: datapath enables and mux selects.
REQ-004 SHALL have outputs ALUSrcB  output  2  (00 regB, 01 const 4, 10 imm, 11 imm for branch target) and ALUCtl  output  4  ALU operation code.
REQ-005 SHALL have outputs illegal_instr  output  1  one-cycle pulse; state  output  4  current state; instret  output  32  retired-instruction count.

Function
REQ-006 SHALL implement a registered Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8; other codes go to FETCH on the next edge.
REQ-007 SHALL drive every output not listed for a state to 0.
REQ-008 SHALL use ALUCtl codes AND=0, OR=1, ADD=2, SUB=6, SLT=7, XOR=12.
REQ-009 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtl=2; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then go to DECODE.
REQ-010 DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtl=2; next state: 0000011 or 0100011 -> MEMADR; 0110011 or 0010011 with legal funct -> EXEC; 1100011 with funct3=000 -> BRANCH; anything else -> FETCH with illegal_instr=1 for this cycle only.
REQ-011 Legal R-type funct3/funct7b5 values SHALL be 000/0 (ADD), 000/1 (SUB), 111 (AND), 110 (OR), 100 (XOR) and 010 (SLT); I-type SHALL accept the same funct3 set, ignore funct7b5, and map 000 to ADD.
REQ-012 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtl=2; go to MEMRD for loads and MEMWR for stores.
REQ-013 MEMRD: MemRead=1, IorD=1; wait for mem_ready, then go to MEMWB.
REQ-014 MEMWB: RegWrite=1, MemtoReg=1; then go to FETCH.
REQ-015 MEMWR: MemWrite=1, IorD=1; wait for mem_ready, then go to FETCH.
REQ-016 EXEC: ALUSrcA=1; ALUSrcB=00 for R-type and 10 for I-type; ALUCtl decoded per REQ-011; then go to ALUWB.
REQ-017 ALUWB: RegWrite=1, MemtoReg=0; then go to FETCH.
REQ-018 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtl=6, PCWriteCond=1, PCSource=1; then go to FETCH. The datapath forms PC load = PCWrite | (PCWriteCond & Zero).
REQ-019 instret SHALL increment by 1, modulo 2^32, on each transition MEMWB->FETCH, MEMWR->FETCH, ALUWB->FETCH or BRANCH->FETCH; illegal instructions SHALL NOT count.
REQ-020 mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-021 Cycle counts with mem_ready tied to 1 SHALL be: load 5, store 4, R/I 4, beq 3, illegal 2.

Reset
REQ-022 While reset=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite and illegal_instr SHALL be forced to 0 combinationally.
REQ-023 The first edge with reset=1 SHALL load state=FETCH and instret=0 from any state, including mid-wait in MEMRD or MEMWR.
REQ-024 After reset deasserts, FETCH outputs SHALL appear in the first cycle.

Verification
REQ-025 Bench SHALL apply reset, then mem_ready=1 with an ADD R-type (0110011/000/0) -> states 0,1,6,7,0; ALUCtl=2 in EXEC; RegWrite=1 in ALUWB; instret=1.
REQ-026 Bench SHALL apply lw (0000011) with mem_ready low for 3 cycles in MEMRD -> MemRead=1 and IorD=1 held 4 cycles; MEMWB follows one cycle after mem_ready; RegWrite=1 and MemtoReg=1.
REQ-027 Bench SHALL apply beq (1100011/000) with Zero=1 -> BRANCH shows ALUCtl=6, PCWriteCond=1, PCSource=1; instret increments.
REQ-028 Bench SHALL apply opcode 1101111 (unsupported) -> illegal_instr=1 for exactly one cycle in DECODE, next state FETCH, instret unchanged.
REQ-029 Bench SHALL assert reset during MEMWR with mem_ready=0 -> MemWrite=0 in the same cycle; state=0 and instret=0 after the edge.
REQ-030 Bench SHALL preload instret to 0xFFFFFFFF via a forced retirement count, then retire one instruction -> instret=0x00000000.
